// File: rtl/score_pkg.sv
// Shared types for the score counter and the 7-segment display path.
package score_pkg;

  // One BCD digit, 0..9
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Four BCD digits, index 3 = thousands, index 0 = ones
  typedef bcd_digit_t [3:0] score_t;

  localparam score_t SCORE_ZERO = 16'h0000;
  localparam score_t SCORE_MAX  = 16'h9999;

  // Digit-serial add sequence
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADD0   = 3'd1,
    ADD1   = 3'd2,
    ADD2   = 3'd3,
    ADD3   = 3'd4,
    COMMIT = 3'd5
  } state_e;

  // BCD magnitude compare. Thousands sit in the top nibble and every nibble
  // is a legal digit, so the packed vector orders exactly like the number.
  function automatic logic bcd_gt(input score_t a, input score_t b);
    return (a > b);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with carry, shared by all four add steps.
module bcd_digit_add
  import score_pkg::*;
(
  input  bcd_digit_t digit,
  input  bcd_digit_t addend,
  input  logic       carry_in,
  output bcd_digit_t digit_out,
  output logic       carry_out
);

  logic [4:0] sum_s;

  // Binary sum then decimal correction when it exceeds 9
  always_comb begin
    sum_s = 5'(digit) + 5'(addend) + 5'(carry_in);
    if (sum_s > 5'd9) begin
      digit_out = 4'(sum_s - 5'd10);
      carry_out = 1'b1;
    end else begin
      digit_out = sum_s[3:0];
      carry_out = 1'b0;
    end
  end

endmodule

// File: rtl/score_bcd_counter.sv
// 4-digit BCD score accumulator, one digit per cycle, committed atomically.
// Optional high-score register and display mux: define SCORE_HISCORE_EN.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int SATURATE   = 1,
  parameter int MAX_POINTS = 9
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       add_valid,
  input  logic [3:0] add_points,
  output logic       add_ready,
  output logic       add_done,
  output logic       overflow,
  input  logic       show_high,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands
);

  localparam bcd_digit_t MAX_ADDEND = bcd_digit_t'(MAX_POINTS);

  state_e     state_q, state_d;
  score_t     work_q, work_d;
  score_t     commit_q, commit_d;
  bcd_digit_t addend_q, addend_d;
  logic       carry_q, carry_d;
  logic       overflow_q, overflow_d;
  logic       done_q, done_d;

  bcd_digit_t add_digit_s, add_in_s, add_sum_s;
  logic       add_cin_s, add_cout_s;
  logic       accept_s;

  assign add_ready = (state_q == IDLE) & ~clear;
  assign accept_s  = add_valid & add_ready;

  bcd_digit_add u_add (
    .digit     (add_digit_s),
    .addend    (add_in_s),
    .carry_in  (add_cin_s),
    .digit_out (add_sum_s),
    .carry_out (add_cout_s)
  );

  // Steer the digit owned by the current add step through the shared adder
  always_comb begin
    add_digit_s = 4'd0;
    add_in_s    = 4'd0;
    add_cin_s   = 1'b0;
    case (state_q)
      ADD0: begin add_digit_s = work_q[0]; add_in_s  = addend_q; end
      ADD1: begin add_digit_s = work_q[1]; add_cin_s = carry_q;  end
      ADD2: begin add_digit_s = work_q[2]; add_cin_s = carry_q;  end
      ADD3: begin add_digit_s = work_q[3]; add_cin_s = carry_q;  end
      default: begin add_digit_s = 4'd0; end
    endcase
  end

  // Next-state logic: clear aborts everything, otherwise walk the add sequence
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    commit_d   = commit_q;
    addend_d   = addend_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    if (clear) begin
      state_d    = IDLE;
      work_d     = SCORE_ZERO;
      commit_d   = SCORE_ZERO;
      carry_d    = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_d  = ADD0;
            work_d   = commit_q;
            carry_d  = 1'b0;
            addend_d = (add_points > MAX_ADDEND) ? MAX_ADDEND : add_points;
          end else begin
            state_d = IDLE;
          end
        end
        ADD0: begin work_d[0] = add_sum_s; carry_d = add_cout_s; state_d = ADD1; end
        ADD1: begin work_d[1] = add_sum_s; carry_d = add_cout_s; state_d = ADD2; end
        ADD2: begin work_d[2] = add_sum_s; carry_d = add_cout_s; state_d = ADD3; end
        ADD3: begin
          state_d = COMMIT;
          carry_d = add_cout_s;
          done_d  = 1'b1;
          if (add_cout_s && (SATURATE != 0)) begin
            work_d = SCORE_MAX;
          end else begin
            work_d[3] = add_sum_s;
          end
          if (add_cout_s) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
        end
        COMMIT: begin
          commit_d = work_q;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Core state registers with synchronous active-low reset
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      work_q     <= SCORE_ZERO;
      commit_q   <= SCORE_ZERO;
      addend_q   <= 4'd0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      commit_q   <= commit_d;
      addend_q   <= addend_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign add_done = done_q;
  assign overflow = overflow_q;

`ifdef SCORE_HISCORE_EN
  score_t hi_q, hi_d;
  score_t disp_q, disp_d;

  // High score follows the committed value upward; display picks score or high
  always_comb begin
    if (!clear && (state_q == COMMIT) && bcd_gt(work_q, hi_q)) begin
      hi_d = work_q;
    end else begin
      hi_d = hi_q;
    end
    disp_d = show_high ? hi_d : commit_d;
  end

  // High score survives clear; only reset zeroes it
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      hi_q   <= SCORE_ZERO;
      disp_q <= SCORE_ZERO;
    end else begin
      hi_q   <= hi_d;
      disp_q <= disp_d;
    end
  end

  assign ones      = disp_q[0];
  assign tens      = disp_q[1];
  assign hundreds  = disp_q[2];
  assign thousands = disp_q[3];
`else
  logic unused_show_high_s;
  assign unused_show_high_s = show_high;

  assign ones      = commit_q[0];
  assign tens      = commit_q[1];
  assign hundreds  = commit_q[2];
  assign thousands = commit_q[3];
`endif

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: two instances (saturating and wrapping) share
// stimulus; an integer-arithmetic model is compared every cycle.
module tb_score_bcd_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, clear, add_valid, show_high;
  logic [3:0] add_points;
  logic       rdy [2];
  logic       done[2];
  logic       ovf [2];
  logic [3:0] o[2], t[2], h[2], th[2];

  int vectors = 0;
  int errors  = 0;

  score_bcd_counter #(.SATURATE(1), .MAX_POINTS(9)) dut_sat (
    .clk_100MHz(clk), .reset_n(reset_n), .clear(clear), .add_valid(add_valid),
    .add_points(add_points), .add_ready(rdy[0]), .add_done(done[0]), .overflow(ovf[0]),
    .show_high(show_high), .ones(o[0]), .tens(t[0]), .hundreds(h[0]), .thousands(th[0]));

  score_bcd_counter #(.SATURATE(0), .MAX_POINTS(9)) dut_wrap (
    .clk_100MHz(clk), .reset_n(reset_n), .clear(clear), .add_valid(add_valid),
    .add_points(add_points), .add_ready(rdy[1]), .add_done(done[1]), .overflow(ovf[1]),
    .show_high(show_high), .ones(o[1]), .tens(t[1]), .hundreds(h[1]), .thousands(th[1]));

  // Model state: plain integers, a countdown since accept, pending results
  int m_score[2], m_pend[2], m_hi[2], m_disp[2];
  bit m_ovf[2], m_pend_ovf[2];
  int m_cnt;
  bit m_done, m_valid;

  function automatic logic [31:0] to_bcd(input int v);
    return 32'({4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_val(input int i);
    return 32'({th[i], h[i], t[i], o[i]});
  endfunction

  task automatic model_step();
    int p, sum;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_score[i] = 0; m_hi[i] = 0; m_ovf[i] = 1'b0;
      end
      m_cnt = 0; m_done = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (clear) begin
        for (int i = 0; i < 2; i++) begin
          m_score[i] = 0; m_ovf[i] = 1'b0;
        end
        m_cnt = 0; m_done = 1'b0;
      end else begin
        m_done = (m_cnt == 4);
        if (m_cnt == 4) begin
          for (int i = 0; i < 2; i++) if (m_pend_ovf[i]) m_ovf[i] = 1'b1;
        end
        if (m_cnt == 5) begin
          for (int i = 0; i < 2; i++) begin
            m_score[i] = m_pend[i];
            if (m_pend[i] > m_hi[i]) m_hi[i] = m_pend[i];
          end
          m_cnt = 0;
        end else if (m_cnt > 0) begin
          m_cnt++;
        end else if (add_valid) begin
          p = (add_points > 4'd9) ? 9 : int'(add_points);
          sum = m_score[0] + p;
          m_pend_ovf[0] = (sum > 9999);
          m_pend[0] = (sum > 9999) ? 9999 : sum;
          sum = m_score[1] + p;
          m_pend_ovf[1] = (sum > 9999);
          m_pend[1] = sum % 10000;
          m_cnt = 1;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
`ifdef SCORE_HISCORE_EN
      m_disp[i] = show_high ? m_hi[i] : m_score[i];
`else
      m_disp[i] = m_score[i];
`endif
    end
  endtask

  // Advance the model on each active edge using inputs stable since last edge
  initial begin
    m_valid = 1'b0;
    m_cnt   = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare every observable output against the model mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("digits%0d", i), dut_val(i), to_bcd(m_disp[i]));
          chk($sformatf("add_done%0d", i), 32'(done[i]), 32'(m_done));
          chk($sformatf("overflow%0d", i), 32'(ovf[i]), 32'(m_ovf[i]));
          chk($sformatf("add_ready%0d", i), 32'(rdy[i]), 32'((m_cnt == 0) && !clear));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_score(input string nm, input int e_sat, input int e_wrap);
    chk({nm, "_sat"},  dut_val(0), to_bcd(e_sat));
    chk({nm, "_wrap"}, dut_val(1), to_bcd(e_wrap));
  endtask

  task automatic do_add(input int p);
    int n;
    n = 0;
    while (rdy[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("add_ready_wait", 32'(rdy[0]), 32'd1);
    add_valid  = 1'b1;
    add_points = 4'(p);
    tick();
    add_valid  = 1'b0;
    repeat (5) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; add_valid = 1'b0; add_points = 4'd0; show_high = 1'b0;
    repeat (3) tick();
    chk_score("reset", 0, 0);
    chk("reset_ready", 32'(rdy[0]), 32'd1);
    chk("reset_ovf", 32'(ovf[0]), 32'd0);
    reset_n = 1'b1;
    tick();

    // Three adds of nine
    do_add(9); chk_score("add9_1", 9, 9);
    do_add(9); chk_score("add9_2", 18, 18);
    do_add(9); chk_score("add9_3", 27, 27);
    chk("no_ovf", 32'(ovf[0]), 32'd0);

    // Ripple 0999 + 1
    do_clear();
    for (int k = 0; k < 111; k++) do_add(9);
    chk_score("pre_999", 999, 999);
    do_add(1); chk_score("ripple_1000", 1000, 1000);

    // Overflow: saturate vs wrap
    do_clear();
    for (int k = 0; k < 1110; k++) do_add(9);
    do_add(5);  chk_score("pre_9995", 9995, 9995);
    do_add(7);  chk_score("ovf_add7", 9999, 2);
    chk("ovf_sat", 32'(ovf[0]), 32'd1);
    chk("ovf_wrap", 32'(ovf[1]), 32'd1);
    do_add(3);  chk_score("sat_add3", 9999, 5);
    do_add(15); chk_score("clamp15", 9999, 14);

    // add_valid held high: one accept per six cycles
    do_clear();
    add_valid = 1'b1; add_points = 4'd2;
    repeat (30) tick();
    add_valid = 1'b0;
    repeat (6) tick();
    chk_score("continuous", 10, 10);

    // Clear in cycle 3 of an add, with add_valid also high
    do_clear();
    do_add(9); do_add(9); do_add(9); do_add(9); do_add(6);
    chk_score("pre_42", 42, 42);
    add_valid = 1'b1; add_points = 4'd5;
    tick();
    add_valid = 1'b0;
    tick(); tick();
    clear = 1'b1; add_valid = 1'b1;
    chk("ready_in_clear", 32'(rdy[0]), 32'd0);
    tick();
    chk_score("clear_abort", 0, 0);
    clear = 1'b0; add_valid = 1'b0;
    repeat (6) tick();
    chk_score("clear_nocommit", 0, 0);

`ifdef SCORE_HISCORE_EN
    do_clear();
    for (int k = 0; k < 16; k++) do_add(9);
    do_add(6);
    do_clear();
    for (int k = 0; k < 8; k++) do_add(9);
    do_add(8);
    show_high = 1'b1; tick(); chk_score("show_high", 150, 150);
    show_high = 1'b0; tick(); chk_score("show_score", 80, 80);
    show_high = 1'b1; reset_n = 1'b0; tick(); chk_score("hi_reset", 0, 0);
    reset_n = 1'b1; show_high = 1'b0; tick();
`endif

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      reset_n    = ($urandom_range(0, 399) != 0);
      clear      = ($urandom_range(0, 49) == 0);
      add_valid  = 1'($urandom_range(0, 1));
      add_points = 4'($urandom_range(0, 15));
      show_high  = 1'($urandom_range(0, 1));
      tick();
    end
    reset_n = 1'b1; clear = 1'b0; add_valid = 1'b0; show_high = 1'b0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Upstream of seg7_control. Accumulates game score events into a 4-digit BCD value (ones/tens/hundreds/thousands). These outputs drive seg7_control's digit inputs directly.
- Adds are done one digit per cycle by a small FSM. Committed outputs only change once per completed add, so the display never shows an intermediate carry state.
- Optional high-score tracking.

Parameters:
- SATURATE, 1, 1 = clamp at 9999 on overflow; 0 = wrap modulo 10000.
- MAX_POINTS, 9, largest accepted addend; larger add_points values are clamped to this (legal range 1..9).

Ports:
- clk_100MHz  in  1  system clock, 100 MHz
- reset_n  in  1  synchronous active-low reset
- clear  in  1  synchronous score clear (active high), e.g. new game
- add_valid  in  1  score event request
- add_points  in  4  points to add (binary 0..15)
- add_ready  out  1  block can accept an event
- add_done  out  1  one-cycle pulse when a committed value updates
- overflow  out  1  sticky: an add exceeded 9999
- show_high  in  1  selects high score onto digit outputs (SCORE_HISCORE_EN only)
- ones  out  4  BCD digit 0 to seg7_control
- tens  out  4  BCD digit 1
- hundreds  out  4  BCD digit 2
- thousands  out  4  BCD digit 3

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; working and committed digits = 0; overflow=0; add_done=0; high score = 0.
  - After reset, add_ready=1.
- add_ready = (state==IDLE) & ~clear. This is combinational.
- Handshake: an event is accepted on an edge where add_valid & add_ready. add_points is sampled at that edge and clamped to MAX_POINTS. add_valid is ignored when not ready; no queuing.
- FSM states: IDLE, ADD0, ADD1, ADD2, ADD3, COMMIT. Transitions are unconditional in sequence; COMMIT returns to IDLE.
- With accept at cycle 0:
  - ADD0 (cyc1): ones += addend.
  - ADD1 (cyc2): tens += carry.
  - ADD2 (cyc3): hundreds += carry.
  - ADD3 (cyc4): thousands += carry.
  - COMMIT (cyc5): committed digits <= working digits; add_done=1 for this cycle.
  - add_ready is high again in cycle 6. Latency: accept -> new outputs visible = 6 edges.
- Digit add rule: sum = digit + in + carry_in. If sum > 9, digit = sum - 10 and carry_out = 1. Otherwise digit = sum and carry_out = 0.
- Addend of 0: the FSM still runs the full sequence. Outputs are unchanged but add_done still pulses.
- Thousands carry-out in ADD3:
  - overflow <= 1 (sticky until clear or reset).
  - SATURATE=1: working digits forced to 9,9,9,9, then committed.
  - SATURATE=0: wrapped value committed.
- Once saturated at 9999, further adds keep 9999 and still pulse add_done.
- clear=1:
  - Next edge: state=IDLE; working and committed digits = 0; overflow=0; add_done=0.
  - An in-flight add is aborted and nothing is committed.
  - clear beats a simultaneous add_valid; the event is not accepted.
  - The high score is NOT cleared.
- reset_n=0 mid-operation: same as clear, plus the high score is zeroed. Reset dominates clear.
- Outputs are registered and always legal BCD (0..9).

Optional Feature:
- Macro: SCORE_HISCORE_EN.
- Defined:
  - A 4-digit high-score register updates in COMMIT when the committed value > stored high score, compared as a BCD magnitude thousands-first.
  - show_high=1 muxes the high score onto ones..thousands (registered, 1-cycle latency); show_high=0 shows the current score.
- Undefined:
  - No high-score register; show_high is ignored.
  - Digit outputs always show the current score.

Decomposition:
- Shared package score_pkg:
  - bcd_digit_t (4-bit) typedef.
  - BCD_MAX=9 constant.
  - 4-digit score struct/array typedef.
  - FSM state enum.
  - Also used by seg7_control's inputs.
- Sub-module bcd_digit_add:
  - Inputs: digit, addend, carry_in. Outputs: digit_out, carry_out.
  - Combinational; instanced once and reused by the FSM each cycle.

Test Plan:
- Reset, then 3 adds of 9 -> after each add_done the outputs read 0009, 0018, 0027; overflow=0.
- Preload 0999 via adds, add 1 -> thousands..ones = 1,0,0,0 at cycle 6 after accept; the intermediate ripple is never visible on the outputs.
- SATURATE=1, score 9995, add 7 -> 9999, overflow=1. Add 3 more -> still 9999. Repeat with SATURATE=0 -> 0002, overflow=1.
- add_valid held high continuously with points=2 -> exactly one accept per 6 cycles; add_ready low in cycles 1-5.
- Assert clear in cycle 3 of an add on score 0042 -> outputs 0000 next edge; no add_done. add_valid together with clear -> not accepted.
- SCORE_HISCORE_EN: score 0150, then clear, score 0080, show_high=1 -> outputs 0150; show_high=0 -> 0080. reset_n low -> high score 0000.
